// File: rtl/top_level_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | top_level_if : MCU handshake and pixel/result bus of the dither top   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface top_level_if #(
  parameter int RGB_SIZE = 8
);
  logic                MCU_TX_RDY;
  logic [RGB_SIZE-1:0] external_SPI_data;
  logic                MCU_RX_RDY;
  logic                data_valid;
  logic                SPI_MISO;

  modport master (
    output MCU_TX_RDY, external_SPI_data,
    input  MCU_RX_RDY, data_valid, SPI_MISO
  );

  modport slave (
    input  MCU_TX_RDY, external_SPI_data,
    output MCU_RX_RDY, data_valid, SPI_MISO
  );
endinterface
`default_nettype wire

// File: rtl/top_level.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | top_level : Floyd-Steinberg dithering accelerator board top.          |
// | Loads an image, dithers it in place to 1 bpp, streams it back.        |
// | Optional serial load path enabled by macro SPI_LOAD_EN.               |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module top_level #(
  parameter int CLOCK_SPEED      = 50000000,
  parameter int PIXEL_COUNTER    = 1,
  parameter int IMAGEX           = 16,
  parameter int IMAGEY           = 16,
  parameter int IMAGE_SIZE       = 256,
  parameter int IMAGEXlog2       = 4,
  parameter int IMAGEYlog2       = 4,
  parameter int IMAGE_ADDR_WIDTH = 8,
  parameter int RGB_SIZE         = 8,
  parameter int ADJ_PIXELS       = 4
) (
  input  wire logic        MAX10_CLK1_50,
  input  wire logic [1:0]  KEY,
  input  wire logic [9:0]  SW,
  input  wire logic        SPI_CLK,
  input  wire logic        SPI_MOSI,
  input  wire logic        SPI_CS,
  output logic      [9:0]  LED,
  output logic      [6:0]  HEX0,
  output logic      [6:0]  HEX1,
  output logic      [6:0]  HEX2,
  output logic      [6:0]  HEX3,
  output logic      [6:0]  HEX4,
  output logic      [6:0]  HEX5,
  top_level_if.slave       bus
);
  localparam int AW = IMAGE_ADDR_WIDTH;
  localparam int WAIT_W = $clog2(PIXEL_COUNTER + 1);
  localparam logic [AW-1:0] LAST_ADDR = AW'(IMAGE_SIZE - 1);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_PROC = 3'd2;
  localparam logic [2:0] ST_OUT  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [2:0] PH_RD   = 3'd0;
  localparam logic [2:0] PH_WR   = 3'd1;
  localparam logic [2:0] PH_NRD  = 3'd2;
  localparam logic [2:0] PH_NWR  = 3'd3;
  localparam logic [2:0] PH_WAIT = 3'd4;

  logic Reset_h;
  assign Reset_h = ~KEY[1];

  logic [2:0]          state_q, state_d, phase_q, phase_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [1:0]          k_q, k_d;
  logic signed [8:0]   err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                rx_rdy_q, rx_rdy_d;
  logic [6:0]          hex0_q, hex1_q, hex2_q, hex3_q;

  logic [RGB_SIZE-1:0] mem_q [IMAGE_SIZE];
  logic [RGB_SIZE-1:0] rdata_q;
  logic                ram_we, ram_re;
  logic [AW-1:0]       ram_addr;
  logic [RGB_SIZE-1:0] ram_wdata;

  logic                w_pause, w_load_wr;
  logic [RGB_SIZE-1:0] w_load_data;

  assign w_pause = SW[9] && (state_q == ST_PROC);

`ifdef SPI_LOAD_EN
  logic [2:0] spi_clk_sync_q;
  logic [1:0] spi_mosi_sync_q, spi_cs_sync_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       w_spi_bit;

  assign w_spi_bit   = spi_clk_sync_q[1] & ~spi_clk_sync_q[2] & ~spi_cs_sync_q[1]
                     & (state_q == ST_LOAD);
  assign w_load_wr   = w_spi_bit && (bit_cnt_q == 3'd7);
  assign w_load_data = {shift_q, spi_mosi_sync_q[1]};

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      spi_clk_sync_q  <= '0;
      spi_mosi_sync_q <= '0;
      spi_cs_sync_q   <= '1;
      bit_cnt_q       <= '0;
      shift_q         <= '0;
    end else begin
      spi_clk_sync_q  <= {spi_clk_sync_q[1:0], SPI_CLK};
      spi_mosi_sync_q <= {spi_mosi_sync_q[0], SPI_MOSI};
      spi_cs_sync_q   <= {spi_cs_sync_q[0], SPI_CS};
      if (state_q != ST_LOAD || spi_cs_sync_q[1]) begin
        bit_cnt_q <= '0;
      end else if (w_spi_bit) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
        shift_q   <= {shift_q[5:0], spi_mosi_sync_q[1]};
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{KEY[0], SW[8:0], bus.external_SPI_data, CLOCK_SPEED > 0};
`else
  assign w_load_wr   = 1'b1;
  assign w_load_data = bus.external_SPI_data;

  logic unused_ok;
  assign unused_ok = ^{KEY[0], SW[8:0], SPI_CLK, SPI_MOSI, SPI_CS, CLOCK_SPEED > 0};
`endif

  // Neighbour selection for the current pixel; index k walks right, down-left, down, down-right.
  logic [IMAGEXlog2-1:0] w_x;
  logic [IMAGEYlog2-1:0] w_y;
  logic                  w_nb_valid;
  logic [AW-1:0]         w_nb_off, w_nb_addr, w_next_addr;
  logic [3:0]            w_weight;

  assign w_x = addr_q[IMAGEXlog2-1:0];
  assign w_y = addr_q[IMAGEXlog2 +: IMAGEYlog2];

  always_comb begin
    w_nb_valid = 1'b0;
    w_nb_off   = '0;
    w_weight   = 4'd0;
    case (k_q)
      2'd0: begin
        w_nb_valid = (w_x != IMAGEXlog2'(IMAGEX - 1));
        w_nb_off   = AW'(1);
        w_weight   = 4'd7;
      end
      2'd1: begin
        w_nb_valid = (w_x != '0) && (w_y != IMAGEYlog2'(IMAGEY - 1));
        w_nb_off   = AW'(IMAGEX - 1);
        w_weight   = 4'd3;
      end
      2'd2: begin
        w_nb_valid = (w_y != IMAGEYlog2'(IMAGEY - 1));
        w_nb_off   = AW'(IMAGEX);
        w_weight   = 4'd5;
      end
      default: begin
        w_nb_valid = (w_x != IMAGEXlog2'(IMAGEX - 1)) && (w_y != IMAGEYlog2'(IMAGEY - 1));
        w_nb_off   = AW'(IMAGEX + 1);
        w_weight   = 4'd1;
      end
    endcase
  end

  assign w_nb_addr   = addr_q + w_nb_off;
  assign w_next_addr = addr_q + AW'(1);

  // Two's-complement low bits match, so an unsigned 13b multiply gives the signed product.
  logic [12:0]         w_prod_u;
  logic signed [12:0]  w_shift;
  logic signed [9:0]   w_sum;
  logic [RGB_SIZE-1:0] w_clamp, w_new;

  assign w_prod_u = {{4{err_q[8]}}, err_q} * {9'd0, w_weight};
  assign w_shift  = $signed(w_prod_u) >>> 4;
  assign w_sum    = {2'b00, rdata_q} + w_shift[9:0];
  assign w_new    = rdata_q[7] ? 8'hFF : 8'h00;

  always_comb begin
    if (w_sum < 10'sd0)        w_clamp = 8'h00;
    else if (w_sum > 10'sd255) w_clamp = 8'hFF;
    else                       w_clamp = w_sum[7:0];
  end

  logic unused_shift;
  assign unused_shift = ^w_shift[12:10];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    addr_d    = addr_q;
    k_d       = k_q;
    err_d     = err_q;
    wait_d    = wait_q;
    rx_rdy_d  = rx_rdy_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = '0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.MCU_TX_RDY) begin
          state_d  = ST_LOAD;
          addr_d   = '0;
          rx_rdy_d = 1'b0;
        end
      end
      ST_LOAD: begin
        if (w_load_wr) begin
          ram_we    = 1'b1;
          ram_wdata = w_load_data;
          if (addr_q == LAST_ADDR) begin
            state_d = ST_PROC;
            phase_d = PH_RD;
            addr_d  = '0;
          end else begin
            addr_d = w_next_addr;
          end
        end
      end
      ST_PROC: begin
        if (!w_pause) begin
          case (phase_q)
            PH_RD: begin
              ram_re  = 1'b1;
              phase_d = PH_WR;
            end
            PH_WR: begin
              ram_we    = 1'b1;
              ram_wdata = w_new;
              err_d     = $signed({1'b0, rdata_q}) - $signed({1'b0, w_new});
              k_d       = '0;
              phase_d   = PH_NRD;
            end
            PH_NRD: begin
              if (w_nb_valid) begin
                ram_addr = w_nb_addr;
                ram_re   = 1'b1;
                phase_d  = PH_NWR;
              end else if (k_q == 2'(ADJ_PIXELS - 1)) begin
                phase_d = PH_WAIT;
                wait_d  = '0;
              end else begin
                k_d = k_q + 2'd1;
              end
            end
            PH_NWR: begin
              ram_addr  = w_nb_addr;
              ram_we    = 1'b1;
              ram_wdata = w_clamp;
              if (k_q == 2'(ADJ_PIXELS - 1)) begin
                phase_d = PH_WAIT;
                wait_d  = '0;
              end else begin
                k_d     = k_q + 2'd1;
                phase_d = PH_NRD;
              end
            end
            default: begin
              if (wait_q == WAIT_W'(PIXEL_COUNTER - 1)) begin
                // Prefetch the next pixel (wraps to 0) so OUT sees data on its first cycle.
                ram_addr = w_next_addr;
                ram_re   = 1'b1;
                phase_d  = PH_RD;
                addr_d   = w_next_addr;
                if (addr_q == LAST_ADDR) state_d = ST_OUT;
              end else begin
                wait_d = wait_q + WAIT_W'(1);
              end
            end
          endcase
        end
      end
      ST_OUT: begin
        ram_addr = w_next_addr;
        ram_re   = 1'b1;
        addr_d   = w_next_addr;
        if (addr_q == LAST_ADDR) begin
          state_d  = ST_DONE;
          rx_rdy_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;  4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;  4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;  4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;  4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

  logic [7:0] w_addr8;
  assign w_addr8 = 8'(addr_q);

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h) begin
      state_q  <= ST_IDLE;
      phase_q  <= PH_RD;
      addr_q   <= '0;
      k_q      <= '0;
      err_q    <= '0;
      wait_q   <= '0;
      rx_rdy_q <= 1'b0;
      hex0_q   <= 7'h7F;
      hex1_q   <= 7'h7F;
      hex2_q   <= 7'h7F;
      hex3_q   <= 7'h7F;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      addr_q   <= addr_d;
      k_q      <= k_d;
      err_q    <= err_d;
      wait_q   <= wait_d;
      rx_rdy_q <= rx_rdy_d;
      // Displays stay blank in IDLE and freeze while paused.
      if (state_q != ST_IDLE && !w_pause) begin
        hex0_q <= seg7(w_addr8[3:0]);
        hex1_q <= seg7(w_addr8[7:4]);
        hex2_q <= seg7(rdata_q[3:0]);
        hex3_q <= seg7(rdata_q[7:4]);
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (ram_we) mem_q[ram_addr] <= ram_wdata;
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
    if (Reset_h)                rdata_q <= '0;
    else if (ram_re && !ram_we) rdata_q <= mem_q[ram_addr];
  end

  assign bus.MCU_RX_RDY = rx_rdy_q;
  assign bus.data_valid = (state_q == ST_OUT);
  assign bus.SPI_MISO   = (state_q == ST_OUT) & rdata_q[7];

  assign LED  = {rx_rdy_q, 5'd0, 1'b0, state_q};
  assign HEX0 = hex0_q;
  assign HEX1 = hex1_q;
  assign HEX2 = hex2_q;
  assign HEX3 = hex3_q;
  assign HEX4 = 7'h7F;
  assign HEX5 = 7'h7F;
endmodule
`default_nettype wire

// File: tb/tb_top_level.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_top_level : randomized scoreboard bench for the dithering top      |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_top_level;
  localparam int N  = 256;
  localparam int W  = 16;
  localparam int H  = 16;
  localparam int NO = 1000000;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic [1:0] KEY;
  logic [9:0] SW;
  logic       SPI_CLK, SPI_MOSI, SPI_CS;
  logic [9:0] LED;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  top_level_if bus ();

  top_level dut (
    .MAX10_CLK1_50(clk), .KEY(KEY), .SW(SW),
    .SPI_CLK(SPI_CLK), .SPI_MOSI(SPI_MOSI), .SPI_CS(SPI_CS),
    .LED(LED), .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2),
    .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int dv_cnt = 0;
  int img [N];
  bit exp_q [$];

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Reference: plain integer Floyd-Steinberg with floor division and clamping.
  task automatic model_push();
    int px [N];
    int old, nw, err, nx, ny, w, prod, c, v;
    for (int i = 0; i < N; i++) px[i] = img[i];
    for (int p = 0; p < N; p++) begin
      old   = px[p];
      nw    = (old >= 128) ? 255 : 0;
      px[p] = nw;
      err   = old - nw;
      for (int k = 0; k < 4; k++) begin
        nx = p % W; ny = p / W; w = 0;
        case (k)
          0: begin nx = nx + 1;                w = 7; end
          1: begin nx = nx - 1; ny = ny + 1;   w = 3; end
          2: begin              ny = ny + 1;   w = 5; end
          default: begin nx = nx + 1; ny = ny + 1; w = 1; end
        endcase
        if (nx >= 0 && nx < W && ny < H) begin
          prod = err * w;
          c = (prod >= 0) ? prod / 16 : -((-prod + 15) / 16);
          v = px[ny * W + nx] + c;
          if (v < 0) v = 0;
          if (v > 255) v = 255;
          px[ny * W + nx] = v;
        end
      end
    end
    for (int p = 0; p < N; p++) exp_q.push_back(px[p] >= 128);
  endtask

  always @(negedge clk) begin
    bit e;
    if (bus.data_valid === 1'b1) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL out_extra: got data_valid=1, expected no further output bits");
      end else begin
        e = exp_q.pop_front();
        check("out_bit", int'(bus.SPI_MISO), int'(e));
      end
    end
  end

  task automatic load_image(input int n_drive);
    @(posedge clk); #1;
    bus.MCU_TX_RDY = 1'b1;
    for (int i = 0; i < N; i++) begin
      @(posedge clk); #1;
      bus.MCU_TX_RDY = 1'b0;
      if (i < n_drive) bus.external_SPI_data = 8'(img[i]);
      if (i == 0) begin
        check("load_state", int'(LED[3:0]), 1);
        check("rx_rdy_cleared", int'(bus.MCU_RX_RDY), 0);
      end
    end
  endtask

  task automatic run_image(input int n_drive, input int pause_at, input int reset_at,
                           input int tx_at);
    bit done = 1'b0;
    int snap = 0;
    for (int i = n_drive; i < N; i++) img[i] = img[n_drive - 1];
    dv_cnt = 0;
    exp_q.delete();
    model_push();
    load_image(n_drive);
    for (int c = 0; c < 20000 && !done; c++) begin
      @(negedge clk);
      if (c == 2) check("proc_state", int'(LED[3:0]), 2);
      if (c == tx_at) bus.MCU_TX_RDY = 1'b1;
      if (c == tx_at + 1) bus.MCU_TX_RDY = 1'b0;
      if (c == pause_at) SW[9] = 1'b1;
      if (c == pause_at + 2) snap = int'({HEX3, HEX2, HEX1, HEX0});
      if (c == pause_at + 30) begin
        check("pause_led", int'(LED[3:0]), 2);
        check("pause_hex_frozen", int'({HEX3, HEX2, HEX1, HEX0}), snap);
      end
      if (c == pause_at + 40) SW[9] = 1'b0;
      if (c == reset_at) begin
        KEY[1] = 1'b0;
        #1;
        check("abort_led", int'(LED), 0);
        check("abort_rx_rdy", int'(bus.MCU_RX_RDY), 0);
        check("abort_valid", int'(bus.data_valid), 0);
        check("abort_hex0", int'(HEX0), 'h7F);
        #1;
        KEY[1] = 1'b1;
        exp_q.delete();
        return;
      end
      if (bus.MCU_RX_RDY === 1'b1) done = 1'b1;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got MCU_RX_RDY=0 after 20000 cycles, expected 1");
      return;
    end
    check("valid_cycles", dv_cnt, N);
    check("bits_left", exp_q.size(), 0);
    check("done_state", int'(LED[3:0]), 4);
    check("done_led9", int'(LED[9]), 1);
    check("done_valid", int'(bus.data_valid), 0);
    check("done_miso", int'(bus.SPI_MISO), 0);
  endtask

  initial begin
    KEY = 2'b01;
    SW = '0;
    SPI_CLK = 1'b0;
    SPI_MOSI = 1'b0;
    SPI_CS = 1'b1;
    bus.MCU_TX_RDY = 1'b0;
    bus.external_SPI_data = '0;
    @(posedge clk); #1;
    KEY = 2'b11;
    repeat (3) @(negedge clk);
    check("rst_led", int'(LED), 0);
    check("rst_rx_rdy", int'(bus.MCU_RX_RDY), 0);
    check("rst_valid", int'(bus.data_valid), 0);
    check("rst_miso", int'(bus.SPI_MISO), 0);
    check("rst_hex0", int'(HEX0), 'h7F);
    check("rst_hex1", int'(HEX1), 'h7F);
    check("rst_hex2", int'(HEX2), 'h7F);
    check("rst_hex3", int'(HEX3), 'h7F);
    check("rst_hex4", int'(HEX4), 'h7F);
    check("rst_hex5", int'(HEX5), 'h7F);

    for (int i = 0; i < N; i++) img[i] = 0;
    run_image(N, NO, NO, NO);
    for (int i = 0; i < N; i++) img[i] = 255;
    run_image(N, NO, NO, NO);
    for (int i = 0; i < N; i++) img[i] = 128;
    run_image(N, NO, NO, NO);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
      run_image(254, NO, NO, NO);
    end
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
    run_image(N, 500, NO, 300);
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
    run_image(N, NO, 700, NO);
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(255, 0));
    run_image(N, NO, NO, NO);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
